jelly2_mipi_csi2_rx_frame_ctl: RTL

- Frame capture controller placed on the AXI4-Stream pixel output of the CSI-2 receiver, ahead of the video DMA or write path.
- Arms on a software command and synchronises to the next frame start (tuser[0]).
- Gates the requested number of whole frames through and drops all other traffic.
- Checks line/frame geometry against programmed width/height, watches for a stalled stream, and reports status and per-frame completion.

---
 rtl/jelly2_mipi_csi2_rx_frame_ctl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/jelly2_mipi_csi2_rx_frame_ctl.sv
// Frame capture controller on the CSI-2 RX AXI4-Stream pixel output.
// It arms on ctl_start and locks to the next frame start. It then passes the
// requested number of whole frames and drops all other traffic. It also checks
// line/frame geometry, watches for a stalled stream and reports status.
// Optional build macro: JELLY2_MIPI_CSI2_RX_FRAME_CTL_TLAST_FIX_EN regenerates
// the output tuser/tlast from the programmed geometry.
module jelly2_mipi_csi2_rx_frame_ctl #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned X_WIDTH       = 16,
  parameter int unsigned Y_WIDTH       = 16,
  parameter int unsigned FRAME_WIDTH   = 16,
  parameter int unsigned TIMEOUT_WIDTH = 24
) (
  input  logic                     aresetn,
  input  logic                     aclk,
  input  logic                     ctl_start,
  input  logic                     ctl_stop,
  input  logic [X_WIDTH-1:0]       param_width,
  input  logic [Y_WIDTH-1:0]       param_height,
  input  logic [FRAME_WIDTH-1:0]   param_frames,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  output logic                     status_busy,
  output logic [FRAME_WIDTH-1:0]   status_frame_count,
  output logic                     status_size_error,
  output logic                     status_timeout,
  output logic                     frame_done,
  input  logic                     s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [DATA_WIDTH-1:0]    s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic                     m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0]    m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [X_WIDTH-1:0]       r_width;
  logic [Y_WIDTH-1:0]       r_height;
  logic [FRAME_WIDTH-1:0]   r_frames;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [X_WIDTH-1:0]       r_x;
  logic [Y_WIDTH-1:0]       r_y;
  logic [TIMEOUT_WIDTH-1:0] r_timer;
  logic [FRAME_WIDTH-1:0]   r_frame_count;
  logic                     r_size_error;
  logic                     r_timeout_flag;
  logic                     r_frame_done;
  logic                     r_stop_pending;

  logic                     w_forward;
  logic                     w_accept;
  logic                     w_fwd_beat;
  logic [X_WIDTH-1:0]       w_cx;
  logic [Y_WIDTH-1:0]       w_cy;
  logic                     w_x_last;
  logic                     w_eol;
  logic                     w_mid_sof;
  logic                     w_size_err;
  logic                     w_frame_end;
  logic [FRAME_WIDTH-1:0]   w_count_inc;
  logic                     w_finish;
  logic                     w_timer_hit;

  // Stream gating: forward in CAPTURE, and the frame-start beat in WAIT_FS
  assign w_forward      = (r_state == ST_CAPTURE) || ((r_state == ST_WAIT_FS) && s_axi4s_tuser);
  assign s_axi4s_tready = w_forward ? m_axi4s_tready : 1'b1;
  assign m_axi4s_tvalid = w_forward && s_axi4s_tvalid;
  assign m_axi4s_tdata  = s_axi4s_tdata;
  assign w_accept       = s_axi4s_tvalid && s_axi4s_tready;
  assign w_fwd_beat     = w_accept && w_forward;

  // A frame-start beat is always treated as position (0,0)
  assign w_cx        = s_axi4s_tuser ? '0 : r_x;
  assign w_cy        = s_axi4s_tuser ? '0 : r_y;
  assign w_x_last    = (w_cx == (r_width - X_WIDTH'(1)));
  assign w_eol       = s_axi4s_tlast || w_x_last;
  assign w_mid_sof   = (r_state == ST_CAPTURE) && s_axi4s_tuser && ((r_x != '0) || (r_y != '0));
  assign w_size_err  = w_fwd_beat && (w_mid_sof || (s_axi4s_tlast != w_x_last));
  assign w_frame_end = w_fwd_beat && s_axi4s_tlast && (w_cy == (r_height - Y_WIDTH'(1)));
  assign w_count_inc = (r_frame_count == '1) ? r_frame_count : (r_frame_count + FRAME_WIDTH'(1));
  assign w_finish    = ((r_frames != '0) && (w_count_inc == r_frames)) || r_stop_pending || ctl_stop;
  assign w_timer_hit = (r_state != ST_IDLE) && (r_timeout != '0) && !w_accept
                       && (r_timer == (r_timeout - TIMEOUT_WIDTH'(1)));

`ifdef JELLY2_MIPI_CSI2_RX_FRAME_CTL_TLAST_FIX_EN
  assign m_axi4s_tuser = (w_cx == '0) && (w_cy == '0);
  assign m_axi4s_tlast = w_x_last;
`else
  assign m_axi4s_tuser = s_axi4s_tuser;
  assign m_axi4s_tlast = s_axi4s_tlast;
`endif

  assign status_busy        = (r_state != ST_IDLE);
  assign status_frame_count = r_frame_count;
  assign status_size_error  = r_size_error;
  assign status_timeout     = r_timeout_flag;
  assign frame_done         = r_frame_done;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ctl_start && !ctl_stop) w_next_state = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (ctl_stop || w_timer_hit) w_next_state = ST_IDLE;
        else if (w_frame_end)        w_next_state = w_finish ? ST_IDLE : ST_WAIT_FS;
        else if (w_fwd_beat)         w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_timer_hit)      w_next_state = ST_IDLE;
        else if (w_frame_end) w_next_state = w_finish ? ST_IDLE : ST_WAIT_FS;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Parameter latch, geometry counters, stall timer and status flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_width        <= '0;
      r_height       <= '0;
      r_frames       <= '0;
      r_timeout      <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_timer        <= '0;
      r_frame_count  <= '0;
      r_size_error   <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_frame_done   <= 1'b0;
      r_stop_pending <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (r_state == ST_IDLE) begin
        r_x            <= '0;
        r_y            <= '0;
        r_timer        <= '0;
        r_stop_pending <= 1'b0;
        if (ctl_start && !ctl_stop) begin
          r_width        <= param_width;
          r_height       <= param_height;
          r_frames       <= param_frames;
          r_timeout      <= param_timeout;
          r_frame_count  <= '0;
          r_size_error   <= 1'b0;
          r_timeout_flag <= 1'b0;
        end
      end else begin
        r_timer <= w_accept ? '0 : (r_timer + TIMEOUT_WIDTH'(1));
        if (w_timer_hit) r_timeout_flag <= 1'b1;
        if (w_size_err)  r_size_error   <= 1'b1;
        if (w_frame_end) r_frame_count  <= w_count_inc;
        if (w_fwd_beat) begin
          if (w_frame_end) begin
            r_x <= '0;
            r_y <= '0;
          end else if (w_eol) begin
            r_x <= '0;
            r_y <= w_cy + Y_WIDTH'(1);
          end else begin
            r_x <= w_cx + X_WIDTH'(1);
            r_y <= w_cy;
          end
        end
        r_stop_pending <= (w_next_state != ST_IDLE)
                          && (r_stop_pending || ((r_state == ST_CAPTURE) && ctl_stop));
      end
    end
  end

endmodule
